// File: rtl/simpledev_access_monitor_if.sv
// CPU-side valid/ack access bus seen by the simpledev access monitor.
interface simpledev_access_monitor_if;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_write,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_write,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/simpledev_access_monitor.sv
// Bus-side capture stage for the simpledev register-model checker.
// Keeps shadow copies of REGA and CHANNEL_TIME_SCALE, queues every mapped
// access in a small FIFO and replays it to the checker as a one-cycle
// ready strobe, spaced so the checker always sees distinct events.
module simpledev_access_monitor #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] REGA_ADDR = 32'd0,
    parameter logic [31:0] CTS_ADDR  = 32'd4,
    parameter logic [31:0] REGA_RST  = 32'd0,
    parameter logic [31:0] CTS_RST   = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    simpledev_access_monitor_if.slave bus,
    input  logic                     chk_busy,
    output logic                     accessType,
    output logic [31:0]              address,
    output logic [31:0]              data,
    output logic                     ready,
    output logic [31:0]              shadow_rega,
    output logic [31:0]              shadow_cts,
    output logic                     err_unmapped,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Bus-side (capture) stage
    logic          hit_rega_p0;
    logic          hit_cts_p0;
    logic          mapped_p0;
    logic          vld_p0;
    logic [31:0]   rdata_p0;
    logic [31:0]   payload_p0;

    // FIFO storage and pointers
    logic          fifo_wr   [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          pop;

    assign fifo_level  = level;
    assign bus.bus_ack = bus.bus_valid && (level < DEPTH_L);
    assign bus.bus_rdata = rdata_p0;

    // Decode the address, pick the pre-access shadow and build the FIFO payload
    always_comb begin
        hit_rega_p0 = (bus.bus_addr == REGA_ADDR);
        hit_cts_p0  = (bus.bus_addr == CTS_ADDR);
        mapped_p0   = hit_rega_p0 || hit_cts_p0;
        vld_p0      = bus.bus_ack && mapped_p0;
        rdata_p0    = 32'd0;
        if (hit_rega_p0) begin
            rdata_p0 = shadow_rega;
        end else if (hit_cts_p0) begin
            rdata_p0 = shadow_cts;
        end
        payload_p0 = bus.bus_write ? bus.bus_wdata : rdata_p0;
    end

    // Shadow registers follow accepted mapped writes; unmapped accesses flag an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_rega  <= REGA_RST;
            shadow_cts   <= CTS_RST;
            err_unmapped <= 1'b0;
        end else begin
            err_unmapped <= bus.bus_ack && !mapped_p0;
            if (vld_p0 && bus.bus_write && hit_rega_p0) begin
                shadow_rega <= bus.bus_wdata;
            end
            if (vld_p0 && bus.bus_write && hit_cts_p0) begin
                shadow_cts <= bus.bus_wdata;
            end
        end
    end

    // FIFO entry storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            fifo_wr[wr_ptr]   <= bus.bus_write;
            fifo_addr[wr_ptr] <= bus.bus_addr;
            fifo_data[wr_ptr] <= payload_p0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (vld_p0) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({vld_p0, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next state: pop only from IDLE, then PRESENT and GAP space the strobes
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((level != '0) && !chk_busy) begin
                    pop     = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Event outputs: strobe ready for the cycle after a pop, hold the event fields until the next pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready      <= 1'b0;
            accessType <= 1'b0;
            address    <= 32'd0;
            data       <= 32'd0;
        end else begin
            ready <= pop;
            if (pop) begin
                accessType <= fifo_wr[rd_ptr];
                address    <= fifo_addr[rd_ptr];
                data       <= fifo_data[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_simpledev_access_monitor.sv
// Scoreboard bench for simpledev_access_monitor: the stimulus side queues the
// expected checker events, a monitor pops and compares on every ready strobe.
module tb_simpledev_access_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chk_busy = 1'b0;
    logic        accessType;
    logic [31:0] address;
    logic [31:0] data;
    logic        ready;
    logic [31:0] shadow_rega;
    logic [31:0] shadow_cts;
    logic        err_unmapped;
    logic [2:0]  fifo_level;

    simpledev_access_monitor_if bus_if ();

    simpledev_access_monitor #(
        .DEPTH     (4),
        .REGA_ADDR (32'd0),
        .CTS_ADDR  (32'd4),
        .REGA_RST  (32'd0),
        .CTS_RST   (32'd0)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .chk_busy     (chk_busy),
        .accessType   (accessType),
        .address      (address),
        .data         (data),
        .ready        (ready),
        .shadow_rega  (shadow_rega),
        .shadow_cts   (shadow_cts),
        .err_unmapped (err_unmapped),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned ready_cyc[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic        prev_ready = 1'b0;
    int          exp_level = 0;
    bit          pend_push = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy model every cycle, event comparison on every strobe
    always @(negedge clk) begin : mon
        ev_t e;
        cyc++;
        if (!rst_n) begin
            exp_level  = 0;
            pend_push  = 1'b0;
            prev_ready = 1'b0;
        end else begin
            exp_level = exp_level + (pend_push ? 1 : 0) - (ready ? 1 : 0);
            check32("fifo_level", 32'(fifo_level), 32'(exp_level));
            if (ready) begin
                check32("ready_one_cycle", 32'(prev_ready), 32'd0);
                ready_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got type=%0d addr=0x%0h data=0x%0h expected none",
                             accessType, address, data);
                end else begin
                    e = exp_q.pop_front();
                    check32("ev_type", 32'(accessType), 32'(e.w));
                    check32("ev_addr", address, e.a);
                    check32("ev_data", data, e.d);
                end
            end
            prev_ready = ready;
            pend_push  = bus_if.bus_ack &&
                         ((bus_if.bus_addr == 32'd0) || (bus_if.bus_addr == 32'd4));
        end
    end

    // Wait n posedges and settle just after the last one
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access, entered just after a posedge; holds request until acked
    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input bit mapped);
        ev_t e;
        int  n;
        bit  acked;
        bus_if.bus_valid = 1'b1;
        bus_if.bus_write = w;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = wd;
        n     = 0;
        acked = 1'b0;
        while (!acked && n < 60) begin
            @(negedge clk);
            if (bus_if.bus_ack) acked = 1'b1;
            else n++;
        end
        if (!acked) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack for addr 0x%0h", a);
        end else begin
            if (!w) check32("bus_rdata", bus_if.bus_rdata, exp_rd);
            if (mapped) begin
                e.w = w;
                e.a = a;
                e.d = w ? wd : exp_rd;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus_if.bus_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_level != 3'd0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check32("drain_pending", 32'(exp_q.size()), 32'd0);
        idle(3);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.bus_valid = 1'b0;
        bus_if.bus_write = 1'b0;
        bus_if.bus_addr  = 32'd0;
        bus_if.bus_wdata = 32'd0;
        idle(3);
        check32("rst_ready", 32'(ready), 32'd0);
        check32("rst_level", 32'(fifo_level), 32'd0);
        check32("rst_rega", shadow_rega, 32'd0);
        check32("rst_cts", shadow_cts, 32'd0);
        check32("rst_addr", address, 32'd0);
        check32("rst_data", data, 32'd0);
        check32("rst_err", 32'(err_unmapped), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single write to REGA: latency and strobe shape
        do_access(1'b1, 32'd0, 32'h1, 32'd0, 1'b1);
        check32("t1_rega", shadow_rega, 32'h1);
        check32("t1_ready_n", 32'(ready), 32'd0);
        idle(1);
        check32("t1_ready_n1", 32'(ready), 32'd1);
        check32("t1_type", 32'(accessType), 32'd1);
        check32("t1_addr", address, 32'd0);
        check32("t1_data", data, 32'h1);
        idle(1);
        check32("t1_ready_n2", 32'(ready), 32'd0);
        check32("t1_hold_data", data, 32'h1);
        wait_drain();

        // CTS write followed by reads of both shadows
        do_access(1'b1, 32'd4, 32'h55, 32'd0, 1'b1);
        do_access(1'b0, 32'd4, 32'd0, 32'h55, 1'b1);
        do_access(1'b0, 32'd0, 32'd0, 32'h1, 1'b1);
        wait_drain();

        // Burst of five writes against a busy checker
        chk_busy = 1'b1;
        ready_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            do_access(1'b1, (i % 2 == 0) ? 32'd0 : 32'd4, 32'h10 + 32'(i), 32'd0, 1'b1);
        end
        bus_if.bus_valid = 1'b1;
        bus_if.bus_write = 1'b1;
        bus_if.bus_addr  = 32'd0;
        bus_if.bus_wdata = 32'h14;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check32("t3_full_ack", 32'(bus_if.bus_ack), 32'd0);
            check32("t3_full_level", 32'(fifo_level), 32'd4);
        end
        idle(1);
        check32("t3_no_ready_busy", 32'(ready_cyc.size()), 32'd0);
        chk_busy = 1'b0;
        do_access(1'b1, 32'd0, 32'h14, 32'd0, 1'b1);
        wait_drain();
        check32("t3_strobes", 32'(ready_cyc.size()), 32'd5);
        if (ready_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                check32("t3_spacing", ready_cyc[i] - ready_cyc[i-1], 32'd3);
            end
        end
        check32("t3_rega", shadow_rega, 32'h14);
        check32("t3_cts", shadow_cts, 32'h13);

        // Unmapped accesses
        do_access(1'b0, 32'd8, 32'd0, 32'd0, 1'b0);
        idle(1);
        do_access(1'b1, 32'd8, 32'hDEAD, 32'd0, 1'b0);
        check32("t4_err_pulse", 32'(err_unmapped), 32'd1);
        idle(1);
        check32("t4_err_clear", 32'(err_unmapped), 32'd0);
        check32("t4_level", 32'(fifo_level), 32'd0);
        check32("t4_rega", shadow_rega, 32'h14);
        check32("t4_cts", shadow_cts, 32'h13);
        idle(4);
        check32("t4_no_ready", 32'(ready), 32'd0);

        // Continuous writes while draining, across pointer wrap
        for (int i = 0; i < 10; i++) begin
            do_access(1'b1, (i % 2 == 0) ? 32'd0 : 32'd4, 32'h100 + 32'(i), 32'd0, 1'b1);
        end
        wait_drain();
        check32("t5_rega", shadow_rega, 32'h108);
        check32("t5_cts", shadow_cts, 32'h109);

        // Reset in PRESENT with three entries still queued
        chk_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b1, (i % 2 == 0) ? 32'd0 : 32'd4, 32'h200 + 32'(i), 32'd0, 1'b1);
        end
        chk_busy = 1'b0;
        begin
            int n = 0;
            bit seen = 1'b0;
            while (!seen && n < 20) begin
                @(negedge clk);
                if (ready) seen = 1'b1;
                else n++;
            end
            check32("t6_ready_seen", 32'(seen), 32'd1);
        end
        #2;
        check32("t6_level_before", 32'(fifo_level), 32'd3);
        rst_n = 1'b0;
        #1;
        check32("t6_ready_async", 32'(ready), 32'd0);
        check32("t6_level", 32'(fifo_level), 32'd0);
        check32("t6_rega", shadow_rega, 32'd0);
        check32("t6_cts", shadow_cts, 32'd0);
        check32("t6_type", 32'(accessType), 32'd0);
        check32("t6_addr", address, 32'd0);
        check32("t6_data", data, 32'd0);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(12);
        check32("t6_ready_after", 32'(ready), 32'd0);
        check32("t6_level_after", 32'(fifo_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simpledev_access_monitor.md
Name: simpledev_access_monitor

Overview:
Bus-side capture stage that sits directly upstream of the simpledev register-model checker FSM.
- Accepts CPU accesses on a valid/ack bus and maintains shadow copies of REGA (addr 0) and CHANNEL_TIME_SCALE (addr 4).
- Queues mapped accesses in a small FIFO.
- Replays each access to the checker as a one-cycle `ready` event carrying accessType/address/data.
- Decouples bus timing from checker evaluation so no access is lost while the checker is busy.

Parameters:
- DEPTH, 4, event FIFO entries (power of 2, 2..16).
- REGA_ADDR, 32'd0, byte address of REGA.
- CTS_ADDR, 32'd4, byte address of CHANNEL_TIME_SCALE.
- REGA_RST, 32'd0, reset value of shadow_rega.
- CTS_RST, 32'd0, reset value of shadow_cts.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- bus_valid  in  1  CPU access request.
- bus_write  in  1  1=write, 0=read.
- bus_addr  in  32  byte address.
- bus_wdata  in  32  write data.
- bus_ack  out  1  access accepted this cycle (combinational).
- bus_rdata  out  32  read data, valid in the cycle bus_ack=1 on a read.
- chk_busy  in  1  checker not in CHECKING; holds events back.
- accessType  out  1  event type, 1=write, 0=read.
- address  out  32  event address.
- data  out  32  event data: write data for writes, shadow value for reads.
- ready  out  1  event strobe to checker, one cycle per event.
- shadow_rega  out  32  current REGA shadow.
- shadow_cts  out  32  current CTS shadow.
- err_unmapped  out  1  one-cycle pulse on an access to an unmapped address.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (async, rst_n=0):
- FIFO flushed, fifo_level=0.
- ready=0, accessType=0, address=0, data=0, err_unmapped=0.
- shadow_rega=REGA_RST, shadow_cts=CTS_RST.
- FSM returns to IDLE. An event in flight is dropped; ready deasserts immediately.

Bus acceptance:
- bus_ack = bus_valid && (fifo_level < DEPTH).
- Mapped = address equals REGA_ADDR or CTS_ADDR (full 32-bit compare).
- Unmapped access: ack is still given when the FIFO is not full, so the CPU never hangs. Nothing is enqueued, shadows are untouched, err_unmapped pulses at the next edge, and bus_rdata=0.

Shadow registers:
- On an accepted mapped write, the matching shadow updates at the same edge the entry is pushed.
- bus_rdata is combinational: the addressed shadow before any update.

FIFO entry contents:
- Entry = {write, addr, payload}.
- payload = bus_wdata for writes.
- payload = the pre-access shadow value for reads.

Output FSM (states IDLE, PRESENT, GAP):
- IDLE: if fifo non-empty and !chk_busy, pop at this edge, load accessType/address/data, ready<=1, go to PRESENT. Otherwise stay.
- PRESENT: ready<=0, go to GAP. ready is high for exactly one cycle, and chk_busy is ignored once PRESENT is entered.
- GAP: go to IDLE. This guarantees at least 2 idle cycles between strobes, so the checker sees distinct events.
- accessType/address/data hold their values until the next pop.

Latency and throughput:
- An access accepted at edge N into an empty FIFO, with FSM in IDLE and chk_busy=0, gives ready=1 from edge N+1 to edge N+2.
- Shadows already reflect the write while ready is high.
- Throughput is 1 event per 3 cycles; the FIFO absorbs bursts.

FIFO boundary cases:
- Push and pop on the same edge: level unchanged, and data ordering is preserved.
- Full: bus_ack=0 and the request waits; there is no overflow path.
- Pointers wrap modulo DEPTH.
- Pop when empty: impossible by construction.

Test Plan:
- Write 0x1 to addr 0 with chk_busy=0 -> ack same cycle; shadow_rega=0x1 after the edge; ready high exactly 1 cycle, 1 cycle later, with accessType=1, address=0, data=0x1.
- Write CTS=0x55, then read addr 4 -> bus_rdata=0x55; second event has accessType=0, address=4, data=0x55.
- Hold chk_busy=1 and issue 5 writes with DEPTH=4 -> first 4 acked, fifo_level=4, 5th stalled with bus_ack=0. Release chk_busy -> 5 strobes in order, each 3 cycles apart.
- Write to addr 8 -> bus_ack=1, err_unmapped one pulse, no ready, shadows unchanged, fifo_level stays 0.
- Continuous writes while events drain -> same-edge push/pop keeps level constant and event order matches bus order across pointer wrap.
- Assert rst_n=0 during PRESENT with 3 entries queued -> ready=0 immediately, fifo_level=0, shadows=REGA_RST/CTS_RST; no stale event after reset is released.
